// File: rtl/hack_pkg.sv
// hack_pkg: shared types and instruction field positions for the Hack ALU sequencer
package hack_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, ERROR} state_t;
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;
    localparam int IS_C    = 15;
    localparam int A_BIT   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JMP_HI  = 2;
    localparam int JMP_LO  = 0;
    // bit positions inside the 3-bit destination field
    localparam int DEST_A  = 2;
    localparam int DEST_D  = 1;
    localparam int DEST_M  = 0;
endpackage

// File: rtl/hack_jump_eval.sv
// hack_jump_eval: decides whether a C-instruction jump is taken from its j bits and the ALU flags
module hack_jump_eval (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);
    assign take = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
endmodule

// File: rtl/hack_alu_sequencer.sv
// hack_alu_sequencer: Hack CPU sequencer holding A/D/PC and driving an external ALU through a ready handshake
module hack_alu_sequencer
    import hack_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16,
    parameter int PC_W        = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [15:0]     inst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [15:0]     inM,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    output logic            alu_ce,
    output logic            alu_rst,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    input  logic            alu_rd_rdy,
    output logic [15:0]     outM,
    output logic            writeM,
    output logic [PC_W-1:0] addressM,
    output logic [PC_W-1:0] pc,
    output logic            err
);
    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(ALU_TIMEOUT - 1);

    state_t          state, nxt;
    logic [15:0]     a, d, res;
    logic            res_zr, res_ng, rst_q, take, accept, busy;
    logic [12:0]     ir;
    logic [CW-1:0]   cnt;
    logic [2:0]      dest;
    alu_ctrl_t       ctrl;

    assign busy   = (state == ISSUE) || (state == WAIT);
    assign accept = inst_ready && inst_valid;
    assign dest   = ir[DEST_HI:DEST_LO];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (ce)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = (accept && inst[IS_C]) ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            // a result arriving on the final allowed cycle still wins over the timeout
            WAIT:    nxt = alu_rd_rdy ? COMMIT : (cnt == LIMIT) ? ERROR : WAIT;
            COMMIT:  nxt = IDLE;
            ERROR:   nxt = ERROR;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        inst_ready = ce && !reset && (state == IDLE);
        alu_ce     = ce && busy;
        writeM     = ce && (state == COMMIT) && dest[DEST_M];
        alu_rst    = reset || rst_q || (state == COMMIT);
        err        = (state == ERROR);
        ctrl       = busy ? alu_ctrl_t'(ir[CTRL_HI:CTRL_LO]) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            d      <= '0;
            pc     <= '0;
            ir     <= '0;
            cnt    <= '0;
            res    <= '0;
            res_zr <= 1'b0;
            res_ng <= 1'b0;
            rst_q  <= 1'b1;
        end else if (ce) begin
            rst_q <= 1'b0;
            cnt   <= (state == WAIT) ? cnt + CW'(1) : '0;
            if (accept && !inst[IS_C]) begin
                a  <= {1'b0, inst[14:0]};
                pc <= pc + PC_W'(1);
            end
            if (accept && inst[IS_C])
                ir <= inst[12:0];
            if (state == WAIT && alu_rd_rdy) begin
                res    <= alu_out;
                res_zr <= alu_zr;
                res_ng <= alu_ng;
            end
            // jump target and addressM both use A as it was before this commit
            if (state == COMMIT) begin
                if (dest[DEST_A])
                    a <= res;
                if (dest[DEST_D])
                    d <= res;
                pc <= take ? a[PC_W-1:0] : pc + PC_W'(1);
            end
        end
    end

    hack_jump_eval u_jump (
        .j    (ir[JMP_HI:JMP_LO]),
        .zr   (res_zr),
        .ng   (res_ng),
        .take (take)
    );

    assign alu_x    = d;
    assign alu_y    = ir[A_BIT] ? inM : a;
    assign alu_zx   = ctrl.zx;
    assign alu_nx   = ctrl.nx;
    assign alu_zy   = ctrl.zy;
    assign alu_ny   = ctrl.ny;
    assign alu_f    = ctrl.f;
    assign alu_no   = ctrl.no;
    assign outM     = res;
    assign addressM = a[PC_W-1:0];
endmodule

// File: tb/tb_hack_alu_sequencer.sv
// tb_hack_alu_sequencer: directed checks of the Hack ALU sequencer against hand-computed values
module tb_hack_alu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic [15:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [15:0] inM = '0;
    logic [15:0] alu_x, alu_y;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_ce, alu_rst;
    logic [15:0] alu_out = '0;
    logic        alu_zr = 1'b0;
    logic        alu_ng = 1'b0;
    logic        alu_rd_rdy = 1'b0;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM, pc;
    logic        err;
    logic [5:0]  ctrl_bus;
    int          vectors = 0;
    int          miscompares = 0;
    int          wm_cnt = 0;
    logic [5:0]  ob_i_ctrl, ob_w_ctrl;
    logic [15:0] ob_i_x, ob_i_y, ob_w_y, ob_c_out;
    logic [14:0] ob_c_addr;
    logic        ob_i_ce, ob_i_rdy, ob_c_wm, ob_c_rst, ob_c_ce, ob_p_rdy, ob_p_wm, ob_p_err;

    hack_alu_sequencer #(.ALU_TIMEOUT(16), .PC_W(15)) dut (
        .clk(clk), .reset(reset), .ce(ce), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inM(inM), .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no), .alu_ce(alu_ce), .alu_rst(alu_rst),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .alu_rd_rdy(alu_rd_rdy),
        .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc), .err(err)
    );

    assign ctrl_bus = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

    always #5 clk = ~clk;

    always @(negedge clk)
        if (writeM === 1'b1)
            wm_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] ins);
        inst = ins;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic exec_c(input logic [15:0] ins, input int dly, input logic [15:0] out,
                          input logic zr, input logic ng);
        inst = ins;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        inst = 16'hFFFF;
        ob_i_ctrl = ctrl_bus;
        ob_i_x = alu_x;
        ob_i_y = alu_y;
        ob_i_ce = alu_ce;
        ob_i_rdy = inst_ready;
        step();
        repeat (dly - 1) step();
        ob_w_ctrl = ctrl_bus;
        ob_w_y = alu_y;
        alu_rd_rdy = 1'b1;
        alu_out = out;
        alu_zr = zr;
        alu_ng = ng;
        step();
        alu_rd_rdy = 1'b0;
        ob_c_wm = writeM;
        ob_c_out = outM;
        ob_c_addr = addressM;
        ob_c_rst = alu_rst;
        ob_c_ce = alu_ce;
        step();
        ob_p_rdy = inst_ready;
        ob_p_wm = writeM;
        ob_p_err = err;
    endtask

    initial begin
        step();
        step();
        chk("rst_pc", pc, 0);
        chk("rst_ready", inst_ready, 0);
        chk("rst_alu_rst", alu_rst, 1);
        chk("rst_writeM", writeM, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_ce", alu_ce, 0);
        chk("rst_outM", outM, 0);
        chk("rst_ctrl", ctrl_bus, 0);
        reset = 1'b0;
        step();
        chk("rel_alu_rst", alu_rst, 0);
        chk("rel_ready", inst_ready, 1);
        // ce low: nothing is accepted
        ce = 1'b0;
        inst = 16'h0005;
        inst_valid = 1'b1;
        #1;
        chk("ce0_ready", inst_ready, 0);
        step();
        chk("ce0_pc", pc, 0);
        ce = 1'b1;
        step();
        inst_valid = 1'b0;
        chk("ainst_pc", pc, 1);
        chk("ainst_addr", addressM, 5);
        chk("ainst_ready", inst_ready, 1);
        chk("ainst_alu_ce", alu_ce, 0);
        // D=A with A=3, then A=5, then D=D+A
        send_a(16'h0003);
        exec_c(16'hEC10, 1, 16'h0003, 1'b0, 1'b0);
        chk("dA_x", alu_x, 3);
        send_a(16'h0005);
        chk("pre_add_pc", pc, 4);
        exec_c(16'hE090, 4, 16'h0008, 1'b0, 1'b0);
        chk("add_ctrl", ob_i_ctrl, 6'b000010);
        chk("add_x", ob_i_x, 3);
        chk("add_y", ob_i_y, 5);
        chk("add_issue_ce", ob_i_ce, 1);
        chk("add_issue_ready", ob_i_rdy, 0);
        chk("add_wait_ctrl", ob_w_ctrl, 6'b000010);
        chk("add_wait_y", ob_w_y, 5);
        chk("add_commit_rst", ob_c_rst, 1);
        chk("add_commit_wm", ob_c_wm, 0);
        chk("add_commit_ce", ob_c_ce, 0);
        chk("add_post_ready", ob_p_rdy, 1);
        chk("add_pc", pc, 5);
        chk("add_D", alu_x, 8);
        // D=M selects inM as y
        inM = 16'hBEEF;
        exec_c(16'hFC10, 2, 16'hBEEF, 1'b0, 1'b1);
        chk("dM_y", ob_i_y, 16'hBEEF);
        chk("dM_D", alu_x, 16'hBEEF);
        chk("dM_pc", pc, 6);
        // M=D memory write
        send_a(16'h0010);
        exec_c(16'hE308, 2, 16'h1234, 1'b0, 1'b0);
        chk("mw_wm", ob_c_wm, 1);
        chk("mw_outM", ob_c_out, 16'h1234);
        chk("mw_addr", ob_c_addr, 15'h0010);
        chk("mw_post_wm", ob_p_wm, 0);
        chk("mw_pulses", wm_cnt, 1);
        chk("mw_D_kept", alu_x, 16'hBEEF);
        chk("mw_pc", pc, 8);
        // jumps
        send_a(16'h0020);
        exec_c(16'hE302, 1, 16'h0000, 1'b1, 1'b0);
        chk("jeq_taken_pc", pc, 15'h0020);
        exec_c(16'hE302, 1, 16'h0005, 1'b0, 1'b0);
        chk("jeq_not_pc", pc, 15'h0021);
        send_a(16'h0100);
        exec_c(16'hEA87, 3, 16'hFFFF, 1'b0, 1'b1);
        chk("jmp_pc", pc, 15'h0100);
        // A=D+1 loads a full 16-bit A; rd_rdy on the 16th WAIT cycle still succeeds
        exec_c(16'hE7E0, 16, 16'h8009, 1'b0, 1'b1);
        chk("lim_err", ob_p_err, 0);
        chk("lim_pc", pc, 15'h0101);
        chk("lim_addr", addressM, 15'h0009);
        // timeout
        inst = 16'hE090;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        chk("to_y_fullA", alu_y, 16'h8009);
        repeat (16) step();
        chk("to_wait16_err", err, 0);
        chk("to_wait16_ce", alu_ce, 1);
        step();
        chk("to_err", err, 1);
        chk("to_ready", inst_ready, 0);
        chk("to_alu_ce", alu_ce, 0);
        inst = 16'h0005;
        inst_valid = 1'b1;
        step();
        step();
        inst_valid = 1'b0;
        chk("to_hold_pc", pc, 15'h0101);
        chk("to_hold_err", err, 1);
        reset = 1'b1;
        step();
        chk("to_rst_err", err, 0);
        chk("to_rst_pc", pc, 0);
        reset = 1'b0;
        step();
        // ce toggling during WAIT, then reset mid-WAIT
        send_a(16'h0007);
        exec_c(16'hEC10, 1, 16'h0007, 1'b0, 1'b0);
        chk("ce_D7", alu_x, 7);
        send_a(16'h0002);
        inst = 16'hE090;
        inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ce = 1'b0;
            step();
            ce = 1'b1;
            step();
        end
        chk("ce_tog_err", err, 0);
        chk("ce_tog_alu_ce", alu_ce, 1);
        chk("ce_tog_pc", pc, 3);
        ce = 1'b0;
        alu_rd_rdy = 1'b1;
        alu_out = 16'h0009;
        step();
        step();
        alu_rd_rdy = 1'b0;
        chk("ce0_rdy_pc", pc, 3);
        chk("ce0_rdy_alu_rst", alu_rst, 0);
        chk("ce0_alu_ce", alu_ce, 0);
        reset = 1'b1;
        step();
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ready", inst_ready, 0);
        chk("mid_rst_alu_rst", alu_rst, 1);
        chk("mid_rst_alu_ce", alu_ce, 0);
        reset = 1'b0;
        ce = 1'b1;
        step();
        chk("mid_rst_D", alu_x, 0);
        chk("mid_rst_A", addressM, 0);
        chk("mid_rst_alu_rst_off", alu_rst, 0);
        chk("mid_rst_ready_on", inst_ready, 1);
        chk("total_pulses", wm_cnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hack_alu_sequencer.md
Name: hack_alu_sequencer

Overview:
- Initiator side of the Hack ALU handshake.
- Accepts 16-bit Hack instructions and executes A-instructions locally; holds the A, D and PC registers.
- For C-instructions it drives zx/nx/zy/ny/f/no and the x/y operands to the ALU, waits for rd_rdy, then commits destinations, the memory write and the jump.
- Sits between instruction fetch/ROM and the ALU; together they form the Hack CPU core.

Parameters:
- ALU_TIMEOUT, 16, maximum WAIT cycles (counting only ce=1 cycles) for alu_rd_rdy before entering ERROR.
- PC_W, 15, program counter / address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; ce=0 freezes all state and registered outputs
- inst  in  16  instruction word
- inst_valid  in  1  inst is valid
- inst_ready  out  1  sequencer accepts inst this cycle
- inM  in  16  data-memory read value at addressM
- alu_x  out  16  ALU x operand (D)
- alu_y  out  16  ALU y operand (a-bit ? inM : A)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control, equal to inst[11:6]
- alu_ce  out  1  ALU enable
- alu_rst  out  1  ALU reset, clears the ALU's sticky done flags
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1 each  ALU flags
- alu_rd_rdy  in  1  ALU result valid
- outM  out  16  memory write data
- writeM  out  1  one-cycle memory write strobe
- addressM  out  PC_W  = A[PC_W-1:0]
- pc  out  PC_W  next instruction address
- err  out  1  sticky ALU-timeout flag

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset values: A=0, D=0, pc=0, state=IDLE, inst_ready=0, alu_ce=0, alu ctrl=0, writeM=0, outM=0, err=0, alu_rst=1.
  - Reset overrides ce and clears any in-flight operation mid-WAIT.
  - alu_rst deasserts on the first cycle after reset is released.
- ce gating: every state, counter and register update below applies only when ce=1.
- IDLE:
  - inst_ready=1 (0 if ce=0). Accept when inst_valid & inst_ready.
  - A-instruction (inst[15]=0): A<=inst[14:0] zero-extended, pc<=pc+1, stay IDLE. Back-to-back A-instructions run at one per cycle.
  - C-instruction (inst[15]=1): latch inst into an internal register, go to ISSUE.
- ISSUE (1 cycle):
  - alu_ce=1; ctrl bits, alu_x and alu_y driven from the latched instruction and current A/D/inM.
  - Operands and ctrl are held stable through WAIT. Clear the timeout counter; go to WAIT.
- WAIT:
  - alu_ce=1; count cycles.
  - alu_rd_rdy=1: capture alu_out/zr/ng, go to COMMIT.
  - Counter reaching ALU_TIMEOUT without rd_rdy: go to ERROR, err<=1.
  - rd_rdy on the same cycle the counter hits the limit counts as success.
- COMMIT (1 cycle):
  - Destinations use d=inst[5:3] (d1=A, d2=D, d3=M):
    - d3: writeM=1, outM=result, addressM=A value before this commit.
    - d1: A<=result.
    - d2: D<=result.
  - Jump: take = (j1&ng)|(j2&zr)|(j3&~ng&~zr), with j=inst[2:0].
    - pc <= take ? old A[PC_W-1:0] : pc+1.
    - Code 111 is an unconditional jump; 000 never jumps.
  - alu_rst=1 and alu_ce=0 this cycle. Return to IDLE; inst_ready is asserted again the next cycle.
- ERROR: inst_ready=0, alu_ce=0, err=1; held until reset.
- Arithmetic and width rules:
  - pc wraps 0x7FFF+1 -> 0 with no flag.
  - Destination A with d1 truncates nothing; A is 16 bits and addressM uses its low PC_W bits.
- inst_valid with no accept: the inst value is don't-care. The sequencer never accepts outside IDLE.
- writeM is a strictly one-cycle pulse and is never asserted outside COMMIT.

Decomposition:
- Package hack_pkg:
  - state enum {IDLE, ISSUE, WAIT, COMMIT, ERROR}
  - alu_ctrl_t packed struct {zx,nx,zy,ny,f,no}
  - instruction field constants: IS_C=15, A_BIT=12, CTRL_HI=11, CTRL_LO=6, DEST_HI=5, DEST_LO=3, JMP_HI=2, JMP_LO=0
  - dest bit indices DEST_A, DEST_D, DEST_M
- Sub-module hack_jump_eval: combinational; inputs j[2:0], zr, ng; output take.

Test Plan:
- Reset then A-instruction 0x0005, valid for 1 cycle -> A=5, pc=1, inst_ready stays 1, no alu_ce.
- With D=3, A=5, instruction D=D+A (0xE090) and ALU model giving rd_rdy after 4 cycles with out=8 -> ctrl=000010, alu_x=3, alu_y=5, D=8, pc+1, alu_rst pulse, writeM=0.
- With A=0x0010, instruction M=D (0xE308), ALU out=0x1234 -> writeM high exactly 1 cycle, outM=0x1234, addressM=0x10.
- With A=0x0020, instruction D;JEQ (0xE302) and ALU zr=1 -> pc=0x20. Repeat with zr=0 -> pc=old+1. JMP (0xEA87) always jumps.
- ALU never raises rd_rdy -> after 16 WAIT cycles err=1, inst_ready=0; a reset then clears err and returns pc=0.
- ce toggling 1/0 every cycle during WAIT, and reset asserted mid-WAIT -> no state advance while ce=0; reset yields IDLE, A=D=pc=0, writeM never asserted.
